// File: rtl/layer_output_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_output_serializer_if
// Description : Element stream between a layer output serializer and the
//               next layer's input. The master drives data/valid/last/index
//               and the slave returns ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_output_serializer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 5
);
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_ready;
    logic                  o_last;
    logic [IDX_W-1:0]      o_index;

    modport master (
        output o_data,
        output o_valid,
        output o_last,
        output o_index,
        input  o_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_last,
        input  o_index,
        output o_ready
    );
endinterface
`default_nettype wire

// File: rtl/layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : layer_output_serializer
// Description : Captures a full layer output vector (NN elements) on a
//               one-cycle strobe and streams it one element per cycle with
//               ready backpressure. A single pending frame buffer allows
//               back-to-back frames without a bubble; a frame arriving while
//               the pending buffer is occupied is dropped and flagged in a
//               sticky overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_output_serializer #(
    parameter int NN         = 30,
    parameter int DATA_WIDTH = 16,
    parameter int LSB_FIRST  = 1,
    parameter int IDX_W      = (NN > 1) ? $clog2(NN) : 1
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_valid,
    input  wire logic [NN*DATA_WIDTH-1:0]   i_data,
    layer_output_serializer_if.master       m_out,
    output logic                            busy,
    output logic                            overflow,
    input  wire logic                       clr_overflow
);

    localparam int c_frame_w = NN * DATA_WIDTH;

    // Index of the final element of a frame in emission order.
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NN - 1);

    // Two-state machine: idle (nothing to emit) or sending a frame.
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_send = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;

    logic [c_frame_w-1:0]   r_active;
    logic [c_frame_w-1:0]   r_pending;
    logic                   r_pend_full;
    logic [IDX_W-1:0]       r_count;
    logic                   r_overflow;

    logic [DATA_WIDTH-1:0]  w_head;
    logic [c_frame_w-1:0]   w_shifted;
    logic                   w_sending;
    logic                   w_last;
    logic                   w_xfer;
    logic                   w_last_xfer;
    logic                   w_drop;

    // ------------------------------------------------------------------------
    // Emission end of the active register and the register after one element
    // has left. Shifting by a whole element fills with zeros, so after a full
    // frame the active register is clear again.
    // ------------------------------------------------------------------------
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_head    = r_active[DATA_WIDTH-1:0];
            assign w_shifted = r_active >> DATA_WIDTH;
        end else begin : g_msb_first
            assign w_head    = r_active[c_frame_w-1 -: DATA_WIDTH];
            assign w_shifted = r_active << DATA_WIDTH;
        end
    endgenerate

    assign w_sending   = (r_state == c_st_send);
    assign w_last      = (r_count == c_last_idx);
    assign w_xfer      = w_sending & m_out.o_ready;
    assign w_last_xfer = w_xfer & w_last;

    // A new frame is lost only when both the active and pending slots are
    // occupied and the active frame is not finishing this cycle. On the
    // finishing cycle the pending frame moves up, which frees its slot.
    assign w_drop      = w_sending & i_valid & r_pend_full & ~w_last_xfer;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: leave SEND only when the last element goes out and
    // there is no follow-on frame (pending or arriving right now).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_valid) begin
                    w_state_nxt = c_st_send;
                end
            end
            c_st_send: begin
                if (w_last_xfer && !r_pend_full && !i_valid) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Output decode, purely from registered state.
    always_comb begin
        m_out.o_valid = w_sending;
        m_out.o_last  = w_sending & w_last;
        m_out.o_index = r_count;
        m_out.o_data  = w_head;
        busy          = w_sending | r_pend_full;
        overflow      = r_overflow;
    end

    // Frame storage: active shift register, pending buffer and element count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_valid) begin
                        r_active <= i_data;
                        r_count  <= '0;
                    end
                end
                default: begin
                    if (w_last_xfer) begin
                        r_count <= '0;
                        if (r_pend_full) begin
                            // Pending frame takes over; a simultaneous new
                            // frame refills the pending slot.
                            r_active <= r_pending;
                            if (i_valid) begin
                                r_pending <= i_data;
                            end else begin
                                r_pend_full <= 1'b0;
                            end
                        end else if (i_valid) begin
                            r_active <= i_data;
                        end else begin
                            r_active <= w_shifted;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_active <= w_shifted;
                            r_count  <= r_count + 1'b1;
                        end
                        if (i_valid && !r_pend_full) begin
                            r_pending   <= i_data;
                            r_pend_full <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_output_serializer
// Description : Scoreboard bench. Stimulus pushes expected elements into
//               per-instance queues; monitors pop and compare on transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_output_serializer;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance 0: NN=4, LSB first. Instance 1: NN=4, MSB first. Instance 2: NN=1.
    logic        iv0, iv1, iv2, clr0, clr1, clr2;
    logic [31:0] id0, id1;
    logic [7:0]  id2;
    logic        busy0, busy1, busy2, ov0, ov1, ov2;

    layer_output_serializer_if #(.DATA_WIDTH(8), .IDX_W(2)) if0 ();
    layer_output_serializer_if #(.DATA_WIDTH(8), .IDX_W(2)) if1 ();
    layer_output_serializer_if #(.DATA_WIDTH(8), .IDX_W(1)) if2 ();

    layer_output_serializer #(.NN(4), .DATA_WIDTH(8), .LSB_FIRST(1), .IDX_W(2)) dut0 (
        .clk(clk), .rst(rst), .i_valid(iv0), .i_data(id0), .m_out(if0),
        .busy(busy0), .overflow(ov0), .clr_overflow(clr0));

    layer_output_serializer #(.NN(4), .DATA_WIDTH(8), .LSB_FIRST(0), .IDX_W(2)) dut1 (
        .clk(clk), .rst(rst), .i_valid(iv1), .i_data(id1), .m_out(if1),
        .busy(busy1), .overflow(ov1), .clr_overflow(clr1));

    layer_output_serializer #(.NN(1), .DATA_WIDTH(8), .LSB_FIRST(1), .IDX_W(1)) dut2 (
        .clk(clk), .rst(rst), .i_valid(iv2), .i_data(id2), .m_out(if2),
        .busy(busy2), .overflow(ov2), .clr_overflow(clr2));

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected LSB-first emission of a 4-element frame.
    task automatic push0(input logic [31:0] f);
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{f[8*i +: 8], 2'(i), (i == 3)});
        end
    endtask

    // Expected MSB-first emission of a 4-element frame.
    task automatic push1(input logic [31:0] f);
        for (int i = 0; i < 4; i++) begin
            q1.push_back('{f[8*(3-i) +: 8], 2'(i), (i == 3)});
        end
    endtask

    task automatic extra(input string name);
        n_checks++;
        $display("FAIL %s: unexpected transfer, queue empty at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (if0.o_valid && if0.o_ready) begin
            if (q0.size() == 0) begin
                extra("m0_xfer");
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("m0_xfer", {21'd0, if0.o_data, if0.o_index, if0.o_last},
                      {21'd0, e.d, e.idx, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (if1.o_valid && if1.o_ready) begin
            if (q1.size() == 0) begin
                extra("m1_xfer");
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("m1_xfer", {21'd0, if1.o_data, if1.o_index, if1.o_last},
                      {21'd0, e.d, e.idx, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (if2.o_valid && if2.o_ready) begin
            if (q2.size() == 0) begin
                extra("m2_xfer");
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("m2_xfer", {22'd0, if2.o_data, if2.o_index, if2.o_last},
                      {22'd0, e.d, e.idx[0], e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iv0 = 0; iv1 = 0; iv2 = 0; clr0 = 0; clr1 = 0; clr2 = 0;
        id0 = '0; id1 = '0; id2 = '0;
        if0.o_ready = 1; if1.o_ready = 1; if2.o_ready = 1;
        rst = 1;
        step(); step();
        check("rst_valid", {31'd0, if0.o_valid}, 0);
        check("rst_last",  {31'd0, if0.o_last}, 0);
        check("rst_index", {30'd0, if0.o_index}, 0);
        check("rst_data",  {24'd0, if0.o_data}, 0);
        check("rst_busy",  {31'd0, busy0}, 0);
        check("rst_ovf",   {31'd0, ov0}, 0);
        rst = 0;
        step();

        // Basic frame
        push0(32'h44332211);
        iv0 = 1; id0 = 32'h44332211;
        step();
        iv0 = 0;
        check("basic_first_valid", {31'd0, if0.o_valid}, 1);
        check("basic_first_data",  {24'd0, if0.o_data}, 32'h11);
        repeat (4) step();
        check("basic_end_valid", {31'd0, if0.o_valid}, 0);
        check("basic_end_busy",  {31'd0, busy0}, 0);

        // Backpressure
        push0(32'h44332211);
        iv0 = 1; id0 = 32'h44332211;
        step();
        iv0 = 0;
        step();
        if0.o_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_data",  {24'd0, if0.o_data}, 32'h22);
            check("bp_hold_index", {30'd0, if0.o_index}, 1);
            check("bp_hold_valid", {31'd0, if0.o_valid}, 1);
        end
        if0.o_ready = 1;
        repeat (3) step();
        check("bp_end_valid", {31'd0, if0.o_valid}, 0);

        // Pending frame, no bubble
        push0(32'h04030201);
        push0(32'h08070605);
        iv0 = 1; id0 = 32'h04030201;
        step();
        iv0 = 0;
        step();
        iv0 = 1; id0 = 32'h08070605;
        step();
        iv0 = 0;
        for (int i = 0; i < 6; i++) begin
            check("pend_no_bubble", {31'd0, if0.o_valid}, 1);
            step();
        end
        check("pend_end_valid", {31'd0, if0.o_valid}, 0);
        check("pend_end_busy",  {31'd0, busy0}, 0);

        // Overflow and simultaneous events
        if0.o_ready = 0;
        push0(32'h24232221);
        push0(32'h28272625);
        iv0 = 1; id0 = 32'h24232221;
        step();
        id0 = 32'h28272625;
        step();
        id0 = 32'h2c2b2a29;
        step();
        iv0 = 0;
        check("ovf_set",      {31'd0, ov0}, 1);
        check("ovf_busy",     {31'd0, busy0}, 1);
        check("ovf_hold_dat", {24'd0, if0.o_data}, 32'h21);
        iv0 = 1; id0 = 32'h3c3b3a39; clr0 = 1;
        step();
        iv0 = 0; clr0 = 0;
        check("ovf_set_beats_clr", {31'd0, ov0}, 1);
        clr0 = 1;
        step();
        clr0 = 0;
        check("ovf_clear", {31'd0, ov0}, 0);
        if0.o_ready = 1;
        repeat (3) step();
        iv0 = 1; id0 = 32'h34333231;
        step();
        iv0 = 0;
        push0(32'h34333231);
        check("simul_no_ovf", {31'd0, ov0}, 0);
        check("simul_b_data", {24'd0, if0.o_data}, 32'h25);
        check("simul_b_idx",  {30'd0, if0.o_index}, 0);
        check("simul_busy",   {31'd0, busy0}, 1);
        repeat (8) step();
        check("simul_end_valid", {31'd0, if0.o_valid}, 0);
        check("simul_end_ovf",   {31'd0, ov0}, 0);

        // MSB-first order and NN=1
        push1(32'h44332211);
        q2.push_back('{8'hA5, 2'd0, 1'b1});
        q2.push_back('{8'h5A, 2'd0, 1'b1});
        iv1 = 1; id1 = 32'h44332211;
        iv2 = 1; id2 = 8'hA5;
        step();
        iv1 = 0;
        check("msb_first_data", {24'd0, if1.o_data}, 32'h44);
        check("nn1_last_a",     {31'd0, if2.o_last}, 1);
        id2 = 8'h5A;
        step();
        iv2 = 0;
        check("nn1_last_b", {31'd0, if2.o_last}, 1);
        check("nn1_data_b", {24'd0, if2.o_data}, 32'h5A);
        repeat (4) step();
        check("msb_end_valid", {31'd0, if1.o_valid}, 0);
        check("nn1_end_valid", {31'd0, if2.o_valid}, 0);

        // Asynchronous reset mid-frame
        q0.push_back('{8'h0a, 2'd0, 1'b0});
        iv0 = 1; id0 = 32'h0d0c0b0a;
        step();
        iv0 = 0;
        step();
        #2;
        rst = 1;
        #1;
        check("arst_valid", {31'd0, if0.o_valid}, 0);
        check("arst_busy",  {31'd0, busy0}, 0);
        check("arst_index", {30'd0, if0.o_index}, 0);
        step();
        rst = 0;
        step();
        push0(32'h54535251);
        iv0 = 1; id0 = 32'h54535251;
        step();
        iv0 = 0;
        check("post_rst_index", {30'd0, if0.o_index}, 0);
        check("post_rst_data",  {24'd0, if0.o_data}, 32'h51);
        repeat (4) step();
        check("post_rst_end", {31'd0, if0.o_valid}, 0);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_output_serializer.md
# layer_output_serializer

Parametrised parallel-to-serial stage between neural-network layers: it captures a layer's full output vector (NN neurons × DATA_WIDTH) on a one-cycle valid strobe and streams it one neuron per cycle to the next layer. It adds the following over the fixed-size inter-layer serializers:
- configurable neuron count, width and emission order;
- downstream ready backpressure;
- a one-frame pending buffer, so back-to-back frames stream without a bubble;
- a sticky overflow flag.

It sits between each Layer_N output (`o_valid[0]`, `x_out`) and the next layer's `x_valid`/`x_in`.

## Interface
Parameters:
- NN, 30, number of neurons (elements) per frame; NN ≥ 1
- DATA_WIDTH, 16, width of one element
- LSB_FIRST, 1, 1: element 0 = i_data[DATA_WIDTH-1:0] is emitted first; 0: the top slice is emitted first
- IDX_W, $clog2(NN) (min 1), width of o_index

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset; clears all state immediately
- i_valid  in  1  frame capture strobe; i_data is sampled when high
- i_data  in  NN*DATA_WIDTH  parallel layer output
- o_data  out  DATA_WIDTH  current element
- o_valid  out  1  o_data is valid
- o_ready  in  1  downstream accepts; an element transfers when o_valid & o_ready
- o_last  out  1  current element is the last of its frame
- o_index  out  IDX_W  position of the current element in emission order (0..NN-1)
- busy  out  1  a frame is being sent or is pending
- overflow  out  1  sticky; a frame was dropped
- clr_overflow  in  1  synchronous clear of overflow

## Operation
- Storage: an active shift register (NN*DATA_WIDTH), a pending register (NN*DATA_WIDTH), a pend_full flag, an element counter, and state.
- States:
  - IDLE: o_valid = 0; pend_full is always 0 in IDLE.
  - SEND: o_valid = 1.
- IDLE with i_valid: load i_data into active, counter ← 0, go to SEND.
- SEND, transfer (o_valid & o_ready): shift active by DATA_WIDTH toward the emission end; counter + 1.
- SEND, transfer of the last element (counter = NN-1):
  - if pend_full: active ← pending, pend_full ← 0, counter ← 0, stay in SEND;
  - else if i_valid: active ← i_data, counter ← 0, stay in SEND;
  - else go to IDLE.
- SEND, i_valid with no last-element transfer:
  - if pend_full = 0: pending ← i_data, pend_full ← 1;
  - if pend_full = 1: the new frame is dropped, pending is unchanged, overflow ← 1.
- SEND, last transfer with pend_full and i_valid in the same cycle: pending moves to active and the new frame goes into pending. No overflow.
- o_data:
  - LSB_FIRST = 1: active[DATA_WIDTH-1:0], shift right.
  - LSB_FIRST = 0: active[NN*DATA_WIDTH-1 -: DATA_WIDTH], shift left.
- o_index = counter. o_last = o_valid & (counter == NN-1).
- busy = (state == SEND) | pend_full.
- overflow: set has priority over clr_overflow in the same cycle.
- o_ready low holds o_data, o_index and o_last stable. o_valid never drops mid-frame.
- NN = 1: o_last is high on every element.
- No arithmetic; the data path is pass-through and never modifies values.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert):
  - state = IDLE, pend_full = 0, counter = 0, active = 0, pending = 0;
  - o_valid = 0, o_last = 0, o_index = 0, o_data = 0, busy = 0, overflow = 0.
- Reset mid-frame aborts the frame with no further valid cycles; the pending frame is lost.
- Latency: i_valid at edge t → o_valid = 1 with element 0 after edge t (registered state, outputs decoded from registers).
- Throughput: one element per cycle with o_ready held high. A frame takes exactly NN valid cycles.
- Back-to-back frames: 0 bubble cycles when the next frame is pending or arrives on the last-transfer cycle.
- Total valid cycles = NN × frames accepted; no extra or trailing valid cycle.

## Test plan
All scenarios use NN=4, DATA_WIDTH=8, LSB_FIRST=1 unless stated.
- Basic frame: i_data=0x44332211, 1-cycle i_valid, o_ready=1 → o_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles; o_index 0..3; o_last only on 0x44; then o_valid=0 and busy=0.
- Backpressure: same frame with o_ready low for 3 cycles after the 2nd element → o_data holds 0x22 with o_index=1; sequence completes intact with exactly 4 transfers.
- Pending frame: frame A=0x04030201, then frame B=0x08070605 two cycles later → 8 consecutive valid cycles 01..08 with no bubble; o_last on 04 and 08.
- Overflow and simultaneous events: A, B, C each 1 cycle apart with o_ready=0 → C dropped, overflow=1; A then B emitted. Pulse clr_overflow together with a new drop → overflow stays 1. Pulse clr_overflow alone → overflow=0. i_valid on A's last transfer while B is pending → B streams next, the new frame is pending, no overflow.
- Order and edge size: LSB_FIRST=0 with 0x44332211 → 0x44,0x33,0x22,0x11. NN=1 → o_last high on the single element.
- Async reset: assert rst mid-frame between edges → o_valid, busy and o_index go to 0 immediately, before the next clock edge; the next frame after release starts at o_index 0 with correct data.
